// File: rtl/pipe_pkg.sv
// Shared types and default widths for pipeline-stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;
  localparam int WB_CTRL_W  = 2;

  // MEM/WB payload: ReadData + AluResult + RegDst
  localparam int WB_DATA_W  = 2 * WORD_W + REG_ADDR_W;

endpackage

// File: rtl/pipe_stage_stats.sv
// Saturating stall/bubble counters for pipe_stage_skid.
// Only present when PIPE_STAGE_STATS_EN is defined.
`ifdef PIPE_STAGE_STATS_EN
module pipe_stage_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_evt,
  input  logic             bubble_evt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  // flush deliberately does not clear these; only rst does
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (bubble_evt && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline-stage register with a 2-entry skid buffer and sync flush.
// PIPE_STAGE_STATS_EN adds stall_cnt/bubble_cnt statistics ports.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// ONE   | main register holds the entry presented downstream
// FULL  | main presented, skid holds the next entry, in_ready=0
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = WB_CTRL_W,
  parameter int DATA_W = WB_DATA_W
`ifdef PIPE_STAGE_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  pipe_state_e       state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;

  // ready comes straight from state so upstream never sees a comb path from out_ready
  assign in_ready  = (state != FULL) && !rst;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl & {CTRL_W{out_valid}};

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      // payload regs keep their value so out_data holds while empty
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (in_fire) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
            state     <= FULL;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  pipe_stage_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk       (clk),
    .rst       (rst),
    .stall_evt (in_valid && !in_ready),
    .bubble_evt(out_ready && !out_valid),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
  );
`endif

endmodule
